// File: rtl/clock_run_ctrl.sv
// Slow-clock run controller: gates divider ticks into whole CPU clock cycles
// for free-run, debounced single-step and HLT halt, and counts delivered cycles.
module clock_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             tick_rise,
  input  logic             tick_fall,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_clken,
  output logic             cpu_clken2,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } st_t;

  st_t           st_q, st_d;
  logic          btn_s1, btn_s2;
  logic          db_lvl;
  logic [DW-1:0] db_cnt;
  logic          db_flip;
  logic          press;
  logic          step_pend;
  logic          pend_clr;
  logic          mid_cycle;
  logic          clken_d, clken2_d;

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
    end
  end

  // Level is accepted on the Nth consecutive differing cycle; any agreement restarts.
  assign db_flip = (btn_s2 != db_lvl) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press   = db_flip & ~db_lvl;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      db_lvl <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      db_lvl <= btn_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  always_comb begin
    st_d     = st_q;
    clken_d  = 1'b0;
    clken2_d = 1'b0;
    pend_clr = 1'b0;
    // An open cycle is always closed, whatever the state.
    if (tick_fall && mid_cycle) begin
      clken2_d = 1'b1;
      if (st_q == STEP) st_d = IDLE;
    end
    if (tick_rise) begin
      case (st_q)
        IDLE: begin
          if (halt_req) begin
            st_d = HALT;
          end else if (run_sw) begin
            st_d     = RUN;
            clken_d  = 1'b1;
            pend_clr = 1'b1;
          end else if (step_pend) begin
            st_d     = STEP;
            clken_d  = 1'b1;
            pend_clr = 1'b1;
          end
        end
        RUN: begin
          if (halt_req)     st_d    = HALT;
          else if (!run_sw) st_d    = IDLE;
          else              clken_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      st_q        <= IDLE;
      cpu_clken   <= 1'b0;
      cpu_clken2  <= 1'b0;
      halted      <= 1'b0;
      mid_cycle   <= 1'b0;
      step_pend   <= 1'b0;
      cycle_count <= '0;
    end else begin
      st_q       <= st_d;
      cpu_clken  <= clken_d;
      cpu_clken2 <= clken2_d;
      halted     <= (st_d == HALT);
      if (clken_d)       mid_cycle <= 1'b1;
      else if (clken2_d) mid_cycle <= 1'b0;
      // Clearing wins over a coincident press: presses while pending collapse.
      if (pend_clr)                    step_pend <= 1'b0;
      else if (press && st_q != HALT)  step_pend <= 1'b1;
      if (clken_d) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_clock_run_ctrl.sv
// Directed bench for clock_run_ctrl: behavioural model checked every cycle,
// plus literal expectations for each test-plan scenario.
module tb_clock_run_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 2;

  logic          sysclk = 1'b0;
  logic          reset, tick_rise, tick_fall, run_sw, step_btn, halt_req;
  logic          cpu_clken, cpu_clken2, halted;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  int vectors = 0;
  int errors  = 0;

  clock_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .sysclk(sysclk), .reset(reset), .tick_rise(tick_rise), .tick_fall(tick_fall),
    .run_sw(run_sw), .step_btn(step_btn), .halt_req(halt_req),
    .cpu_clken(cpu_clken), .cpu_clken2(cpu_clken2), .halted(halted),
    .state(state), .cycle_count(cycle_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 step, 3 halt; 'open' = cycle begun, not closed.
  bit mvalid = 0;
  int mode, count, deb_diff;
  bit open, pend, s1, s2, deb, m_c, m_c2, m_halted;

  always @(posedge sysclk) begin
    bit press, clr;
    int old_mode;
    if (reset) begin
      mvalid = 1; mode = 0; count = 0; deb_diff = 0;
      open = 0; pend = 0; s1 = 0; s2 = 0; deb = 0; m_c = 0; m_c2 = 0; m_halted = 0;
    end else begin
      press = 0;
      if (s2 != deb) begin
        deb_diff++;
        if (deb_diff == DEB) begin
          deb = s2; deb_diff = 0; press = deb;
        end
      end else deb_diff = 0;
      s2 = s1; s1 = step_btn;

      old_mode = mode; clr = 0; m_c = 0; m_c2 = 0;
      if (tick_fall && open) begin
        m_c2 = 1; open = 0;
        if (mode == 2) mode = 0;
      end
      if (tick_rise) begin
        if (mode == 0) begin
          if (halt_req)    mode = 3;
          else if (run_sw) begin mode = 1; m_c = 1; clr = 1; end
          else if (pend)   begin mode = 2; m_c = 1; clr = 1; end
        end else if (mode == 1) begin
          if (halt_req)     mode = 3;
          else if (!run_sw) mode = 0;
          else              m_c = 1;
        end
      end
      if (m_c) open = 1;
      pend = clr ? 1'b0 : (pend || (press && old_mode != 3));
      count = (count + int'(m_c)) % (1 << CW);
      m_halted = (mode == 3);
    end
  end

  always @(negedge sysclk) begin
    if (mvalid) begin
      chk("m_clken",  32'(cpu_clken),   32'(m_c));
      chk("m_clken2", 32'(cpu_clken2),  32'(m_c2));
      chk("m_halted", 32'(halted),      32'(m_halted));
      chk("m_state",  32'(state),       32'(mode));
      chk("m_count",  32'(cycle_count), 32'(count));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic rise(output logic got);
    @(negedge sysclk) tick_rise = 1'b1;
    @(negedge sysclk) tick_rise = 1'b0;
    got = cpu_clken;
    cyc(2);
  endtask

  task automatic fall(output logic got);
    @(negedge sysclk) tick_fall = 1'b1;
    @(negedge sysclk) tick_fall = 1'b0;
    got = cpu_clken2;
    cyc(2);
  endtask

  task automatic do_reset();
    @(negedge sysclk) reset = 1'b1;
    @(negedge sysclk) reset = 1'b0;
  endtask

  task automatic press_btn();
    step_btn = 1'b1; cyc(12);
    step_btn = 1'b0; cyc(10);
  endtask

  initial begin
    logic g;
    reset = 1'b1; tick_rise = 0; tick_fall = 0; run_sw = 0; step_btn = 0; halt_req = 0;
    cyc(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(cycle_count), 0);
    chk("rst_pulses", 32'({cpu_clken, cpu_clken2, halted}), 0);
    reset = 1'b0;

    // Free-run
    run_sw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rise(g); chk("run_clken", 32'(g), 1);
      fall(g); chk("run_clken2", 32'(g), 1);
    end
    chk("run_count", 32'(cycle_count), 3);
    chk("run_state", 32'(state), 1);

    // Single-step with a bouncing button
    do_reset();
    run_sw = 1'b0;
    step_btn = 1'b1; cyc(2); step_btn = 1'b0; cyc(2); step_btn = 1'b1; cyc(12);
    rise(g); chk("step_clken1", 32'(g), 1);
    chk("step_state2", 32'(state), 2);
    fall(g); chk("step_clken2", 32'(g), 1);
    chk("step_state0", 32'(state), 0);
    for (int i = 0; i < 3; i++) begin
      rise(g); chk("step_noclken", 32'(g), 0);
      fall(g); chk("step_noclken2", 32'(g), 0);
    end
    chk("step_count", 32'(cycle_count), 1);
    step_btn = 1'b0; cyc(10);

    // Halt between rise and fall
    do_reset();
    run_sw = 1'b1;
    rise(g); fall(g);
    rise(g); chk("halt_pre_clken", 32'(g), 1);
    halt_req = 1'b1;
    fall(g); chk("halt_fall_done", 32'(g), 1);
    rise(g); chk("halt_no_clken", 32'(g), 0);
    chk("halt_state", 32'(state), 3);
    chk("halt_flag", 32'(halted), 1);
    fall(g); chk("halt_no_clken2", 32'(g), 0);
    press_btn();
    rise(g); chk("halt_press_ign", 32'(g), 0);
    chk("halt_count", 32'(cycle_count), 2);
    halt_req = 1'b0;
    do_reset();
    chk("halt_rst_state", 32'(state), 0);
    chk("halt_rst_count", 32'(cycle_count), 0);

    // Mode switch mid-cycle
    run_sw = 1'b1;
    rise(g); chk("mode_clken", 32'(g), 1);
    run_sw = 1'b0;
    fall(g); chk("mode_fall_done", 32'(g), 1);
    rise(g); chk("mode_no_clken", 32'(g), 0);
    chk("mode_state", 32'(state), 0);

    // Priority: halt beats run beats pending step
    do_reset();
    press_btn();
    run_sw = 1'b1; halt_req = 1'b1;
    rise(g); chk("prio_no_clken", 32'(g), 0);
    chk("prio_state", 32'(state), 3);
    halt_req = 1'b0; run_sw = 1'b0;

    // Counter wrap, then reset between rise and fall
    do_reset();
    run_sw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rise(g);
      chk("wrap_count", 32'(cycle_count), 32'((i + 1) % 4));
      fall(g);
    end
    rise(g); chk("rstmid_clken", 32'(g), 1);
    run_sw = 1'b0;
    do_reset();
    chk("rstmid_outs", 32'({cpu_clken, cpu_clken2, halted, state, cycle_count}), 0);
    fall(g); chk("rstmid_no_clken2", 32'(g), 0);
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
